// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 round-datapath sequencer: init, one AD block, NB_PT plaintext
// blocks (last one merged into finalisation) and tag release.
//
// Ports:
//   clock_i, resetb_i     clock, async active-low reset
//   abort_i               abort request (only with ASCON_ABORT_EN)
//   start_i               start a message (sampled in IDLE/DONE)
//   key_i                 128-bit key K, stable for the whole message
//   data_valid_i          AD/PT block present on the xor-up input
//   data_ack_o            block consumed this cycle
//   select_o              datapath mux: take the external initial state
//   ena_xor_up_o          xor block into x0
//   ena_xor_down_o        xor data_xor_down_o into x1..x4
//   ena_reg_o             load round result (0 = hold)
//   round_o               round-constant index 0..11
//   data_xor_down_o       xor-down operand (zero when not enabled)
//   cipher_valid_o        cipher word valid this cycle
//   block_cnt_o           current plaintext block index
//   busy_o                message in progress
//   tag_valid_o           x3,x4 hold the tag
// Optional: define ASCON_ABORT_EN to add abort_i.

module ascon_ctrl_fsm #(
    parameter int NB_PT = 4
) (
    input  logic         clock_i,
    input  logic         resetb_i,
`ifdef ASCON_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic         data_valid_i,
    output logic         data_ack_o,
    output logic         select_o,
    output logic         ena_xor_up_o,
    output logic         ena_xor_down_o,
    output logic         ena_reg_o,
    output logic [3:0]   round_o,
    output logic [255:0] data_xor_down_o,
    output logic         cipher_valid_o,
    output logic [3:0]   block_cnt_o,
    output logic         busy_o,
    output logic         tag_valid_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_AD,
        S_AD,
        S_WAIT_PT,
        S_PT,
        S_WAIT_FIN,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_PT  = 4'(NB_PT - 2);
    localparam logic [3:0] RND_LAST = 4'd11;
    localparam logic [3:0] RND_HALF = 4'd6;

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic [3:0] blk_q, blk_d;
    logic       last_rnd;

    assign last_rnd = (rnd_q == RND_LAST);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rnd_d           = rnd_q;
        blk_d           = blk_q;
        data_ack_o      = 1'b0;
        select_o        = 1'b0;
        ena_xor_up_o    = 1'b0;
        ena_xor_down_o  = 1'b0;
        ena_reg_o       = 1'b0;
        data_xor_down_o = '0;
        cipher_valid_o  = 1'b0;
        tag_valid_o     = 1'b0;
        busy_o          = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = S_INIT;
                    rnd_d   = '0;
                    blk_d   = '0;
                end
            end
            S_INIT: begin
                ena_reg_o = 1'b1;
                select_o  = (rnd_q == 4'd0);
                if (last_rnd) begin
                    ena_xor_down_o  = 1'b1;
                    data_xor_down_o = {128'h0, key_i};
                    state_d         = S_WAIT_AD;
                    rnd_d           = '0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_WAIT_AD: begin
                if (data_valid_i) begin
                    state_d = S_AD;
                    rnd_d   = RND_HALF;
                end
            end
            S_AD: begin
                ena_reg_o = 1'b1;
                if (rnd_q == RND_HALF) begin
                    ena_xor_up_o = 1'b1;
                    data_ack_o   = 1'b1;
                end
                if (last_rnd) begin
                    // domain separation bit into the lsb of x4
                    ena_xor_down_o  = 1'b1;
                    data_xor_down_o = 256'h1;
                    state_d         = S_WAIT_PT;
                    rnd_d           = '0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_WAIT_PT: begin
                if (data_valid_i) begin
                    state_d = S_PT;
                    rnd_d   = RND_HALF;
                end
            end
            S_PT: begin
                ena_reg_o = 1'b1;
                if (rnd_q == RND_HALF) begin
                    ena_xor_up_o   = 1'b1;
                    data_ack_o     = 1'b1;
                    cipher_valid_o = 1'b1;
                end
                if (last_rnd) begin
                    // the next block is absorbed by FIN, so K goes
                    // into x1,x2 at the end of this one
                    if (blk_q == LAST_PT) begin
                        ena_xor_down_o  = 1'b1;
                        data_xor_down_o = {key_i, 128'h0};
                        state_d         = S_WAIT_FIN;
                    end else begin
                        state_d = S_WAIT_PT;
                    end
                    blk_d = blk_q + 4'd1;
                    rnd_d = '0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_WAIT_FIN: begin
                if (data_valid_i) begin
                    state_d = S_FIN;
                    rnd_d   = '0;
                end
            end
            S_FIN: begin
                ena_reg_o = 1'b1;
                if (rnd_q == 4'd0) begin
                    ena_xor_up_o   = 1'b1;
                    data_ack_o     = 1'b1;
                    cipher_valid_o = 1'b1;
                end
                if (last_rnd) begin
                    ena_xor_down_o  = 1'b1;
                    data_xor_down_o = {128'h0, key_i};
                    state_d         = S_DONE;
                    rnd_d           = '0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                busy_o      = 1'b0;
                tag_valid_o = 1'b1;
                if (start_i) begin
                    state_d = S_INIT;
                    rnd_d   = '0;
                    blk_d   = '0;
                end
            end
            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
                rnd_d   = '0;
                blk_d   = '0;
            end
        endcase

`ifdef ASCON_ABORT_EN
        // abort overrides every transition and gates enables at once
        if (abort_i && busy_o) begin
            state_d         = S_IDLE;
            rnd_d           = '0;
            blk_d           = '0;
            data_ack_o      = 1'b0;
            select_o        = 1'b0;
            ena_xor_up_o    = 1'b0;
            ena_xor_down_o  = 1'b0;
            ena_reg_o       = 1'b0;
            data_xor_down_o = '0;
            cipher_valid_o  = 1'b0;
        end
`endif
    end

    assign round_o     = rnd_q;
    assign block_cnt_o = blk_q;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed-step testbench for ascon_ctrl_fsm (NB_PT=4).
// Expected values come from the hand-derived cycle timeline of one message.

module tb_ascon_ctrl_fsm;

    localparam logic [127:0] K = 128'h000102030405060708090A0B0C0D0E0F;

    logic         clock_i;
    logic         resetb_i;
    logic         abort_i;
    logic         start_i;
    logic [127:0] key_i;
    logic         data_valid_i;
    logic         data_ack_o;
    logic         select_o;
    logic         ena_xor_up_o;
    logic         ena_xor_down_o;
    logic         ena_reg_o;
    logic [3:0]   round_o;
    logic [255:0] data_xor_down_o;
    logic         cipher_valid_o;
    logic [3:0]   block_cnt_o;
    logic         busy_o;
    logic         tag_valid_o;

    int n_vec = 0;
    int n_err = 0;

    ascon_ctrl_fsm #(.NB_PT(4)) dut (
        .clock_i         (clock_i),
        .resetb_i        (resetb_i),
`ifdef ASCON_ABORT_EN
        .abort_i         (abort_i),
`endif
        .start_i         (start_i),
        .key_i           (key_i),
        .data_valid_i    (data_valid_i),
        .data_ack_o      (data_ack_o),
        .select_o        (select_o),
        .ena_xor_up_o    (ena_xor_up_o),
        .ena_xor_down_o  (ena_xor_down_o),
        .ena_reg_o       (ena_reg_o),
        .round_o         (round_o),
        .data_xor_down_o (data_xor_down_o),
        .cipher_valid_o  (cipher_valid_o),
        .block_cnt_o     (block_cnt_o),
        .busy_o          (busy_o),
        .tag_valid_o     (tag_valid_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    logic [15:0] obs;
    logic [5:0]  ens;
    assign obs = {data_ack_o, select_o, ena_xor_up_o, ena_xor_down_o,
                  ena_reg_o, round_o, cipher_valid_o, block_cnt_o,
                  busy_o, tag_valid_o};
    assign ens = {data_ack_o, select_o, ena_xor_up_o, ena_xor_down_o,
                  ena_reg_o, cipher_valid_o};

    task automatic chk(input string tag, input logic [255:0] o,
                       input logic [255:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // expected outputs at cycle c of a message started at cycle 0
    task automatic exp_run(input int c, output logic [15:0] e,
                           output logic [255:0] xd);
        logic ack, sel, xup, xdn, rg, cv, bsy, tag;
        logic [3:0] rnd, blk;
        int b, p;
        ack = 0; sel = 0; xup = 0; xdn = 0; rg = 0; cv = 0;
        bsy = 0; tag = 0; rnd = 0; blk = 0; xd = '0;
        if (c >= 1 && c <= 12) begin
            bsy = 1; rg = 1; rnd = 4'(c - 1); sel = (c == 1);
            if (c == 12) begin xdn = 1; xd = {128'h0, K}; end
        end else if (c == 13) begin
            bsy = 1;
        end else if (c >= 14 && c <= 19) begin
            bsy = 1; rg = 1; rnd = 4'(c - 8);
            if (c == 14) begin ack = 1; xup = 1; end
            if (c == 19) begin xdn = 1; xd = 256'h1; end
        end else if (c >= 20 && c <= 40) begin
            b = (c - 20) / 7;
            p = (c - 20) % 7;
            bsy = 1; blk = 4'(b);
            if (p != 0) begin
                rg = 1; rnd = 4'(p + 5);
                if (p == 1) begin ack = 1; xup = 1; cv = 1; end
                if (p == 6 && b == 2) begin
                    xdn = 1; xd = {K, 128'h0};
                end
            end
        end else if (c == 41) begin
            bsy = 1; blk = 4'd3;
        end else if (c >= 42 && c <= 53) begin
            bsy = 1; rg = 1; blk = 4'd3; rnd = 4'(c - 42);
            if (c == 42) begin ack = 1; xup = 1; cv = 1; end
            if (c == 53) begin xdn = 1; xd = {128'h0, K}; end
        end else if (c == 54) begin
            tag = 1; blk = 4'd3;
        end
        e = {ack, sel, xup, xdn, rg, rnd, cv, blk, bsy, tag};
    endtask

    task automatic chk_cyc(input string run, input int c);
        logic [15:0]  e;
        logic [255:0] xd;
        exp_run(c, e, xd);
        chk($sformatf("%s_ctl_c%0d", run, c), 256'(obs), 256'(e));
        chk($sformatf("%s_xd_c%0d", run, c), data_xor_down_o, xd);
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        resetb_i     = 1'b0;
        abort_i      = 1'b0;
        start_i      = 1'b0;
        key_i        = K;
        data_valid_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
        chk("reset_ctl", 256'(obs), 256'h0);
        chk("reset_xd", data_xor_down_o, 256'h0);
        #3 resetb_i = 1'b1;

        // run 1: valid tied high
        step();
        start_i      = 1'b1;
        data_valid_i = 1'b1;
        chk_cyc("run1", 0);
        for (int c = 1; c <= 54; c++) begin
            step();
            start_i = 1'b0;
            chk_cyc("run1", c);
        end

        // run 2: restart from DONE, start_i held high while busy
        start_i = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            step();
            if (c == 54) start_i = 1'b0;
            chk_cyc("run2", c);
        end

        // run 3: valid low for 10 cycles in WAIT_PT
        start_i = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            step();
            start_i = 1'b0;
            chk_cyc("run3", c);
        end
        data_valid_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_cyc($sformatf("run3_hold%0d", k), 20);
        end
        step();
        chk_cyc("run3_lastwait", 20);
        data_valid_i = 1'b1;
        #1;
        chk_cyc("run3_validhi", 20);
        step();
        chk_cyc("run3_pt", 21);

        // run 4: reset mid-INIT at round 5
        #2 resetb_i = 1'b0;
        #1;
        chk("rst_pt_ctl", 256'(obs), 256'h0);
        #1 resetb_i = 1'b1;
        start_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            start_i = 1'b0;
            chk_cyc("run4", c);
        end
        #3 resetb_i = 1'b0;
        #1;
        chk("rst_init_ctl", 256'(obs), 256'h0);
        chk("rst_init_xd", data_xor_down_o, 256'h0);
        #1 resetb_i = 1'b1;
        start_i = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            step();
            start_i = 1'b0;
            chk_cyc("run5", c);
        end

`ifdef ASCON_ABORT_EN
        // abort at second PT block, round 8 (cycle 30)
        start_i = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            start_i = 1'b0;
            chk_cyc("run6", c);
        end
        abort_i = 1'b1;
        #1;
        chk("abort_ens", 256'(ens), 256'h0);
        chk("abort_xd", data_xor_down_o, 256'h0);
        step();
        abort_i = 1'b0;
        chk("abort_idle", 256'(obs), 256'h0);
        start_i = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            step();
            start_i = 1'b0;
            chk_cyc("run7", c);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
